// File: rtl/uart_sched_defs.sv
// Shared definitions for the UART transmit scheduler and the MMU.
package uart_sched_defs;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_RISE = 2'd2,
    ST_WAIT_FALL = 2'd3
  } sched_state_e;

  localparam int STAT_TX_IDLE    = 0;
  localparam int STAT_FIFO_EMPTY = 1;
  localparam int STAT_FIFO_FULL  = 2;
  localparam int STAT_OVERFLOW   = 3;
  localparam int STAT_TIMEOUT    = 4;

  localparam logic [31:0] UART_DATA_ADDR   = 32'h0000_4000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_4004;

  // Assemble the software-visible status word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic tx_idle,
                                              input logic fifo_empty,
                                              input logic fifo_full,
                                              input logic overflow,
                                              input logic timeout);
    logic [31:0] s;
    s                  = 32'h0;
    s[STAT_TX_IDLE]    = tx_idle;
    s[STAT_FIFO_EMPTY] = fifo_empty;
    s[STAT_FIFO_FULL]  = fifo_full;
    s[STAT_OVERFLOW]   = overflow;
    s[STAT_TIMEOUT]    = timeout;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous DEPTH x 8 FIFO. Push while full is ignored unless a pop
// happens in the same cycle; pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Gate requests against occupancy and compute the next pointers/count.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Queues CPU bytes and launches them into uart_tx one at a time, with a
// watchdog on the busy handshake and sticky overflow/timeout flags.
module uart_tx_sched
  import uart_sched_defs::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_write,
  input  logic [7:0]               cpu_data,
  input  logic                     status_clr,
  input  logic                     uart_busy,
  output logic                     uart_write_en,
  output logic [7:0]               uart_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              status
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  sched_state_e  state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          uart_write_en_q, uart_write_en_d;
  logic [7:0]    uart_data_q, uart_data_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;

  logic          pop;
  logic          tmo_set;
  logic          ovf_set;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          tx_idle;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cpu_write),
    .push_data (cpu_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scheduler next-state: launch when data is queued and the core is free.
  always_comb begin
    state_d         = state_q;
    tmo_cnt_d       = tmo_cnt_q;
    uart_write_en_d = 1'b0;
    uart_data_d     = uart_data_q;
    pop             = 1'b0;
    tmo_set         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !uart_busy) begin
          state_d         = ST_LAUNCH;
          uart_write_en_d = 1'b1;
          uart_data_d     = fifo_head;
        end
      end
      ST_LAUNCH: begin
        pop       = 1'b1;
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (uart_busy) begin
          state_d = ST_WAIT_FALL;
        end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_WAIT_FALL: begin
        if (!uart_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a set event in the same cycle as status_clr wins.
  always_comb begin
    ovf_set    = cpu_write && fifo_full && !pop;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (status_clr) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (ovf_set) overflow_d = 1'b1;
    if (tmo_set) timeout_d  = 1'b1;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      tmo_cnt_q       <= '0;
      uart_write_en_q <= 1'b0;
      uart_data_q     <= 8'h00;
      overflow_q      <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_cnt_q       <= tmo_cnt_d;
      uart_write_en_q <= uart_write_en_d;
      uart_data_q     <= uart_data_d;
      overflow_q      <= overflow_d;
      timeout_q       <= timeout_d;
    end
  end

  assign tx_idle       = (state_q == ST_IDLE) && fifo_empty && !uart_busy;
  assign uart_write_en = uart_write_en_q;
  assign uart_data     = uart_data_q;
  assign status        = pack_status(tx_idle, fifo_empty, fifo_full,
                                     overflow_q, timeout_q);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple uart_tx busy model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_write;
  logic [7:0]  cpu_data;
  logic        status_clr;
  logic        uart_busy;
  logic        uart_write_en;
  logic [7:0]  uart_data;
  logic [4:0]  fifo_count;
  logic [31:0] status;

  int n_vec = 0;
  int n_err = 0;

  // uart_tx model: busy rises the cycle after write_en, stays 20 cycles
  logic        model_en;
  logic        force_busy;
  logic        mbusy;
  int          mcnt;
  int          n_launch = 0;
  logic [7:0]  launched[$];

  assign uart_busy = (model_en & mbusy) | force_busy;

  uart_tx_sched #(.DEPTH(16), .BUSY_TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_write     (cpu_write),
    .cpu_data      (cpu_data),
    .status_clr    (status_clr),
    .uart_busy     (uart_busy),
    .uart_write_en (uart_write_en),
    .uart_data     (uart_data),
    .fifo_count    (fifo_count),
    .status        (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (uart_write_en && model_en) begin
      mbusy <= 1'b1;
      mcnt  <= 20;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt  <= 0;
      mbusy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (uart_write_en) begin
      launched.push_back(uart_data);
      n_launch++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    cpu_write = 1'b1;
    cpu_data  = b;
    @(negedge clk);
    cpu_write = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (status[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int n0;
    rst        = 1'b1;
    cpu_write  = 1'b0;
    cpu_data   = 8'h00;
    status_clr = 1'b0;
    model_en   = 1'b1;
    force_busy = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_status", status, 32'h3);
    chk("rst_count", {27'b0, fifo_count}, 32'd0);
    chk("rst_data", {24'b0, uart_data}, 32'h00);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_status", status, 32'h3);
    chk("idle_count", {27'b0, fifo_count}, 32'd0);
    chk("idle_no_launch", n_launch, 0);

    // Single byte 0x41: launch two cycles after the write
    push_byte(8'h41);
    chk("single_cnt_n1", {27'b0, fifo_count}, 32'd1);
    chk("single_we_n1", {31'b0, uart_write_en}, 32'd0);
    chk("single_status_n1", status, 32'h0);
    @(negedge clk);
    chk("single_we_n2", {31'b0, uart_write_en}, 32'd1);
    chk("single_data_n2", {24'b0, uart_data}, 32'h41);
    @(negedge clk);
    chk("single_we_n3", {31'b0, uart_write_en}, 32'd0);
    chk("single_cnt_n3", {27'b0, fifo_count}, 32'd0);
    chk("single_txidle_busy", {31'b0, status[0]}, 32'd0);
    wait_tx_idle(100, "single_drain_bound");
    chk("single_one_pulse", n_launch, 1);
    chk("single_status_end", status, 32'h3);

    // Burst of 17 with busy held: fills, drops the 17th, flags overflow
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    chk("burst_count", {27'b0, fifo_count}, 32'd16);
    chk("burst_status", status, 32'h0000_000C);
    launched.delete();
    force_busy = 1'b0;
    wait_tx_idle(1000, "burst_drain_bound");
    chk("burst_n_launched", launched.size(), 16);
    for (int i = 0; i < 16 && i < launched.size(); i++)
      chk($sformatf("burst_order_%0d", i), {24'b0, launched[i]}, i);
    chk("burst_ovf_kept", status, 32'h0000_000B);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    chk("burst_clr", status, 32'h3);

    // Full FIFO with a write landing in the pop cycle
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    chk("full_count", {27'b0, fifo_count}, 32'd16);
    launched.delete();
    force_busy = 1'b0;
    @(negedge clk);
    chk("full_launch_aligned", {31'b0, uart_write_en}, 32'd1);
    push_byte(8'hAA);
    chk("full_count_kept", {27'b0, fifo_count}, 32'd16);
    chk("full_no_ovf", {31'b0, status[3]}, 32'd0);
    wait_tx_idle(1000, "full_drain_bound");
    chk("full_n_launched", launched.size(), 17);
    for (int i = 0; i < 16 && i < launched.size(); i++)
      chk($sformatf("full_order_%0d", i), {24'b0, launched[i]}, 32'h20 + i);
    if (launched.size() == 17)
      chk("full_order_last", {24'b0, launched[16]}, 32'hAA);
    chk("full_status_end", status, 32'h3);

    // Busy never rises: byte abandoned after 64 cycles in WAIT_RISE
    model_en = 1'b0;
    push_byte(8'h55);
    repeat (65) @(negedge clk);
    chk("tmo_not_yet", {31'b0, status[4]}, 32'd0);
    @(negedge clk);
    chk("tmo_status", status, 32'h0000_0013);
    chk("tmo_count", {27'b0, fifo_count}, 32'd0);
    push_byte(8'h66);
    @(negedge clk);
    chk("tmo_relaunch_we", {31'b0, uart_write_en}, 32'd1);
    chk("tmo_relaunch_data", {24'b0, uart_data}, 32'h66);
    repeat (70) @(negedge clk);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    chk("tmo_clr", status, 32'h3);
    model_en = 1'b1;

    // Asynchronous reset in WAIT_FALL with five bytes queued
    for (int i = 0; i < 6; i++) push_byte(8'h71 + 8'(i));
    repeat (2) @(negedge clk);
    chk("arst_pre_count", {27'b0, fifo_count}, 32'd5);
    chk("arst_pre_data", {24'b0, uart_data}, 32'h71);
    chk("arst_pre_busy", {31'b0, uart_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", {31'b0, uart_write_en}, 32'd0);
    chk("arst_data", {24'b0, uart_data}, 32'h00);
    chk("arst_count", {27'b0, fifo_count}, 32'd0);
    chk("arst_status", status, 32'h3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n0 = n_launch;
    repeat (60) @(negedge clk);
    chk("arst_no_launch", n_launch, n0);
    chk("arst_count_end", {27'b0, fifo_count}, 32'd0);
    chk("arst_status_end", status, 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
